mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 144 ++++++++++++++
 tb/tb_mult_div_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO registers.
// Results are computed on latched operands and land when busy falls.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDUop,
    input  logic        start,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        mdu_stall
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        md_req;
    logic        is_mul_req;
    logic [63:0] prod_u;
    logic [63:0] prod_s;
    logic        sdiv;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic [31:0] quot;
    logic [31:0] rem;

    assign md_req = start && (MDUop == OP_MULT || MDUop == OP_MULTU ||
                              MDUop == OP_DIV  || MDUop == OP_DIVU);
    assign is_mul_req = (MDUop == OP_MULT) || (MDUop == OP_MULTU);

    assign busy      = (state_q == RUN);
    assign mdu_stall = busy || md_req;
    assign HI        = hi_q;
    assign LO        = lo_q;

    // Low 64 bits of the sign-extended product equal the signed product.
    assign prod_u = {32'b0, a_q} * {32'b0, b_q};
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};

    // Signed divide via magnitudes; 0x80000000 / -1 wraps to 0x80000000.
    assign sdiv   = (op_q == OP_DIV);
    assign a_mag  = (sdiv && a_q[31]) ? (~a_q + 32'd1) : a_q;
    assign b_mag  = (sdiv && b_q[31]) ? (~b_q + 32'd1) : b_q;
    assign quot_u = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    assign rem_u  = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    assign quot   = (sdiv && (a_q[31] ^ b_q[31])) ? (~quot_u + 32'd1) : quot_u;
    assign rem    = (sdiv && a_q[31]) ? (~rem_u + 32'd1) : rem_u;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            IDLE: begin
                if (md_req) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = MDUop;
                    cnt_d   = is_mul_req ? 32'(MULT_CYCLES) : 32'(DIV_CYCLES);
                    state_d = RUN;
                end else if (start && MDUop == OP_MTHI) begin
                    hi_d = A;
                end else if (start && MDUop == OP_MTLO) begin
                    lo_d = A;
                end
            end
            RUN: begin
                if (cnt_q <= 32'd1) begin
                    cnt_d   = 32'd0;
                    state_d = IDLE;
                    case (op_q)
                        OP_MULT: begin
                            hi_d = prod_s[63:32];
                            lo_d = prod_s[31:0];
                        end
                        OP_MULTU: begin
                            hi_d = prod_u[63:32];
                            lo_d = prod_u[31:0];
                        end
                        OP_DIV, OP_DIVU: begin
                            if (b_q != 32'd0) begin
                                hi_d = rem;
                                lo_d = quot;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 3'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_mult_div_unit;

    logic        clk;
    logic        reset_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDUop;
    logic        start;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        mdu_stall;

    int checks = 0;
    int errors = 0;
    int n;

    mult_div_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .A         (A),
        .B         (B),
        .MDUop     (MDUop),
        .start     (start),
        .HI        (HI),
        .LO        (LO),
        .busy      (busy),
        .mdu_stall (mdu_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Issue one op for a single cycle starting at a falling edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic exp_stall);
        @(negedge clk);
        A = a;
        B = b;
        MDUop = op;
        start = 1'b1;
        #1;
        chk("stall_on_start", {31'b0, mdu_stall}, {31'b0, exp_stall});
        @(negedge clk);
        start = 1'b0;
        MDUop = 3'b000;
    endtask

    // mode 0 plain, 1 perturb A/B, 2 inject mtlo 0xDEAD, 3 reset on 4th cycle
    task automatic wait_done(input int mode, output int cycles);
        cycles = 0;
        while (busy && cycles < 200) begin
            cycles++;
            chk("stall_while_busy", {31'b0, mdu_stall}, 32'd1);
            if (mode == 1) begin
                A = $urandom;
                B = $urandom;
            end
            if (mode == 2 && cycles == 2) begin
                A = 32'h0000DEAD;
                MDUop = 3'b110;
                start = 1'b1;
            end
            if (mode == 2 && cycles == 3) begin
                MDUop = 3'b000;
                start = 1'b0;
            end
            if (mode == 3 && cycles == 4) begin
                #2;
                reset_n = 1'b0;
                #1;
                chk("rst_busy", {31'b0, busy}, 32'd0);
                chk("rst_hi", HI, 32'd0);
                chk("rst_lo", LO, 32'd0);
                return;
            end
            @(negedge clk);
        end
        if (cycles >= 200)
            chk("busy_timeout", 32'(cycles), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        A = 32'd0;
        B = 32'd0;
        MDUop = 3'b000;
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_stall", {31'b0, mdu_stall}, 32'd0);
        reset_n = 1'b1;

        // mult -2 * 3
        issue(3'b001, 32'hFFFFFFFE, 32'd3, 1'b1);
        wait_done(0, n);
        chk("mult_cycles", 32'(n), 32'd5);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFFA);
        chk("stall_after", {31'b0, mdu_stall}, 32'd0);

        issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        wait_done(0, n);
        chk("multu_cycles", 32'(n), 32'd5);
        chk("multu_hi", HI, 32'hFFFFFFFE);
        chk("multu_lo", LO, 32'h00000001);

        // div -7 / 2
        issue(3'b011, 32'hFFFFFFF9, 32'd2, 1'b1);
        wait_done(0, n);
        chk("div_cycles", 32'(n), 32'd10);
        chk("div_lo", LO, 32'hFFFFFFFD);
        chk("div_hi", HI, 32'hFFFFFFFF);

        issue(3'b100, 32'd7, 32'd0, 1'b1);
        wait_done(0, n);
        chk("divu0_cycles", 32'(n), 32'd10);
        chk("divu0_lo", LO, 32'hFFFFFFFD);
        chk("divu0_hi", HI, 32'hFFFFFFFF);

        issue(3'b011, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        wait_done(0, n);
        chk("divovf_lo", LO, 32'h80000000);
        chk("divovf_hi", HI, 32'h00000000);

        issue(3'b100, 32'd100, 32'd7, 1'b1);
        wait_done(0, n);
        chk("divu_lo", LO, 32'd14);
        chk("divu_hi", HI, 32'd2);

        // div 7 / -2: remainder takes dividend sign
        issue(3'b011, 32'd7, 32'hFFFFFFFE, 1'b1);
        wait_done(0, n);
        chk("divneg_lo", LO, 32'hFFFFFFFD);
        chk("divneg_hi", HI, 32'd1);

        // No-op encodings and start=0 must leave everything alone
        issue(3'b111, 32'h55555555, 32'd1, 1'b0);
        chk("op7_busy", {31'b0, busy}, 32'd0);
        chk("op7_lo", LO, 32'hFFFFFFFD);
        @(negedge clk);
        A = 32'hAAAA0000;
        MDUop = 3'b001;
        #1;
        chk("nostart_stall", {31'b0, mdu_stall}, 32'd0);
        @(negedge clk);
        chk("nostart_busy", {31'b0, busy}, 32'd0);
        chk("nostart_hi", HI, 32'd1);
        MDUop = 3'b000;

        issue(3'b101, 32'h12345678, 32'd0, 1'b0);
        chk("mthi_hi", HI, 32'h12345678);
        chk("mthi_busy", {31'b0, busy}, 32'd0);

        issue(3'b110, 32'h0BADF00D, 32'd0, 1'b0);
        chk("mtlo_lo", LO, 32'h0BADF00D);

        // mtlo during RUN is ignored
        issue(3'b011, 32'd100, 32'd7, 1'b1);
        wait_done(2, n);
        chk("inj_cycles", 32'(n), 32'd10);
        chk("inj_lo", LO, 32'd14);
        chk("inj_hi", HI, 32'd2);

        // reset on the 4th busy cycle
        issue(3'b011, 32'd50, 32'd3, 1'b1);
        wait_done(3, n);
        @(negedge clk);
        chk("rst_hold_hi", HI, 32'd0);
        reset_n = 1'b1;
        issue(3'b001, 32'd2, 32'd3, 1'b1);
        wait_done(0, n);
        chk("postrst_cycles", 32'(n), 32'd5);
        chk("postrst_lo", LO, 32'd6);
        chk("postrst_hi", HI, 32'd0);

        // Operand changes during RUN have no effect
        issue(3'b001, 32'd1000, 32'd2000, 1'b1);
        wait_done(1, n);
        chk("latch_lo", LO, 32'h001E8480);
        chk("latch_hi", HI, 32'd0);
        A = 32'hFFFFFFFF;
        B = 32'hFFFFFFFF;
        #1;
        chk("no_comb_path", LO, 32'h001E8480);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
